// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sequencing controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      MAIN_GRN_BASE,
      MAIN_GRN_EXT,
      MAIN_YEL,
      WALK,
      SIDE_GRN_BASE,
      SIDE_GRN_EXT,
      SIDE_YEL
   } state_t;

   localparam logic [1:0] INT_BASE = 2'b00;
   localparam logic [1:0] INT_EXT  = 2'b01;
   localparam logic [1:0] INT_YEL  = 2'b10;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   function automatic logic [1:0] interval_of(input state_t s);
      case (s)
         MAIN_GRN_BASE, SIDE_GRN_BASE: interval_of = INT_BASE;
         MAIN_YEL, SIDE_YEL:           interval_of = INT_YEL;
         default:                      interval_of = INT_EXT;
      endcase
   endfunction

   function automatic logic [2:0] main_of(input state_t s);
      case (s)
         MAIN_GRN_BASE, MAIN_GRN_EXT: main_of = LAMP_G;
         MAIN_YEL:                    main_of = LAMP_Y;
         default:                     main_of = LAMP_R;
      endcase
   endfunction

   function automatic logic [2:0] side_of(input state_t s);
      case (s)
         SIDE_GRN_BASE, SIDE_GRN_EXT: side_of = LAMP_G;
         SIDE_YEL:                    side_of = LAMP_Y;
         default:                     side_of = LAMP_R;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_fsm_interval_timer.sv
// Phase down-counter: a loaded value of N expires on the Nth tick; 0 counts as 1.
module interval_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   assign expired = tick && (cnt <= CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
      else if (tick && !expired)
         cnt <= cnt - CNT_W'(1);
   end

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: phase FSM, walk latch, two-edge load delay and registered lamp decode.
module traffic_light_fsm
   import traffic_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_sync,
   input  logic             tick_1hz,
   input  logic             sensor_sync,
   input  logic             walk_req_sync,
   input  logic [CNT_W-1:0] tp_val,
   output logic [1:0]       interval,
   output logic [2:0]       main_lamps,
   output logic [2:0]       side_lamps,
   output logic             walk_lamp
);

   state_t     state, nxt;
   logic [1:0] ld_pipe;
   logic       walk_latch;
   logic       tick_en;
   logic       expired;

   // The store needs one edge to fetch tp_val for a new interval; ticks wait for the load.
   assign tick_en = tick_1hz && !(|ld_pipe) && !reset_sync;

   interval_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset_sync),
      .load     (ld_pipe[1]),
      .load_val (tp_val),
      .tick     (tick_en),
      .expired  (expired)
   );

   always_comb begin
      nxt = state;
      case (state)
         MAIN_GRN_BASE: nxt = sensor_sync ? MAIN_GRN_EXT : MAIN_YEL;
         MAIN_GRN_EXT:  nxt = MAIN_YEL;
         MAIN_YEL:      nxt = walk_latch ? WALK : SIDE_GRN_BASE;
         WALK:          nxt = SIDE_GRN_BASE;
         SIDE_GRN_BASE: nxt = sensor_sync ? SIDE_GRN_EXT : SIDE_YEL;
         SIDE_GRN_EXT:  nxt = SIDE_YEL;
         SIDE_YEL:      nxt = MAIN_GRN_BASE;
         default:       nxt = MAIN_GRN_BASE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_sync) begin
         state      <= MAIN_GRN_BASE;
         interval   <= INT_BASE;
         main_lamps <= LAMP_G;
         side_lamps <= LAMP_R;
         walk_lamp  <= 1'b0;
         walk_latch <= 1'b0;
         ld_pipe    <= 2'b01;
      end else begin
         ld_pipe <= {ld_pipe[0], 1'b0};
         // A request on the WALK entry edge survives so it is served next round.
         if (walk_req_sync)
            walk_latch <= 1'b1;
         else if (expired && nxt == WALK)
            walk_latch <= 1'b0;
         if (expired) begin
            state      <= nxt;
            interval   <= interval_of(nxt);
            main_lamps <= main_of(nxt);
            side_lamps <= side_of(nxt);
            walk_lamp  <= (nxt == WALK);
            ld_pipe    <= 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: phase-table sequences, reset corner case, randomized run vs a phase model.
module tb_traffic_light_fsm;

   logic       clk;
   logic       reset_sync;
   logic       tick_1hz;
   logic       sensor_sync;
   logic       walk_req_sync;
   logic [3:0] tp_val;
   logic [1:0] interval;
   logic [2:0] main_lamps;
   logic [2:0] side_lamps;
   logic       walk_lamp;

   traffic_light_fsm #(.CNT_W(4)) dut (
      .clk           (clk),
      .reset_sync    (reset_sync),
      .tick_1hz      (tick_1hz),
      .sensor_sync   (sensor_sync),
      .walk_req_sync (walk_req_sync),
      .tp_val        (tp_val),
      .interval      (interval),
      .main_lamps    (main_lamps),
      .side_lamps    (side_lamps),
      .walk_lamp     (walk_lamp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sensor;
      int         walk_at;  // 0 none, 1 pulse on first cycle, 2 pulse with the final tick
      int         base;     // base interval length to program at phase start, -1 keeps it
      logic [8:0] outs;     // {interval, main, side, walk}
      int         dur;
   } vec_t;

   vec_t vec[16];
   int   checks = 0;
   int   errors = 0;

   logic [3:0] tbl[3];
   // Phase order: 0 MGB, 1 MGE, 2 MY, 3 WALK, 4 SGB, 5 SGE, 6 SY
   logic [8:0] ph_out[7];
   int m_ph, m_since, m_left;
   bit m_latch;

   function automatic int succ(input int ph, input bit sens, input bit latch);
      case (ph)
         0: succ = sens ? 1 : 2;
         1: succ = 2;
         2: succ = latch ? 3 : 4;
         3: succ = 4;
         4: succ = sens ? 5 : 6;
         5: succ = 6;
         default: succ = 0;
      endcase
   endfunction

   function automatic logic [8:0] outs_now();
      outs_now = {interval, main_lamps, side_lamps, walk_lamp};
   endfunction

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_edge(input bit t, input bit w, input bit r);
      bit ex;
      int nph;
      if (r) begin
         m_ph = 0; m_since = 0; m_left = 0; m_latch = 0;
      end else begin
         ex = 0;
         nph = m_ph;
         if (m_since == 0) m_since = 1;
         else if (m_since == 1) begin
            m_left = (tp_val == 0) ? 1 : int'(tp_val);
            m_since = 2;
         end else if (t) begin
            if (m_left <= 1) ex = 1;
            else m_left--;
         end
         if (ex) nph = succ(m_ph, sensor_sync, m_latch);
         m_latch = w || (m_latch && !(ex && nph == 3));
         if (ex) begin
            m_ph = nph;
            m_since = 0;
         end
      end
   endtask

   task automatic step(input bit t, input bit w, input bit r);
      logic [1:0] prev_int;
      tick_1hz = t; walk_req_sync = w; reset_sync = r;
      prev_int = interval;
      model_edge(t, w, r);
      @(posedge clk);
      #1;
      tp_val = (^prev_int === 1'bx || prev_int == 2'b11) ? tbl[0] : tbl[prev_int];
      @(negedge clk);
      chk("model", outs_now(), ph_out[m_ph]);
      tick_1hz = 0; walk_req_sync = 0; reset_sync = 0;
   endtask

   task automatic run_phase(input int i, input int k0);
      vec_t r;
      int   ticks, k;
      bit   done, t, w;
      r = vec[i];
      if (r.base >= 0) tbl[0] = 4'(r.base);
      sensor_sync = r.sensor;
      chk($sformatf("phase%0d_outputs", i), outs_now(), r.outs);
      ticks = 0; k = k0; done = 0;
      while (!done && k < 200) begin
         t = (k % 2 == 1);
         w = (r.walk_at == 1 && k == k0) ||
             (r.walk_at == 2 && t && k >= 3 && ticks == r.dur - 1);
         step(t, w, 0);
         if (t && k >= 3) ticks++;
         if (outs_now() !== r.outs) done = 1;
         k++;
      end
      if (!done) begin
         errors++;
         $display("FAIL phase%0d_timeout: got no phase change required change within 200 cycles", i);
      end
      checks++;
      if (ticks != r.dur) begin
         errors++;
         $display("FAIL phase%0d_ticks: got %0d required %0d", i, ticks, r.dur);
      end
   endtask

   function automatic vec_t mk(input logic s, input int wa, input int b, input logic [8:0] o, input int d);
      mk.sensor = s; mk.walk_at = wa; mk.base = b; mk.outs = o; mk.dur = d;
   endfunction

   initial begin
      logic [8:0] rst_out;
      ph_out[0] = {2'b00, 3'b001, 3'b100, 1'b0};
      ph_out[1] = {2'b01, 3'b001, 3'b100, 1'b0};
      ph_out[2] = {2'b10, 3'b010, 3'b100, 1'b0};
      ph_out[3] = {2'b01, 3'b100, 3'b100, 1'b1};
      ph_out[4] = {2'b00, 3'b100, 3'b001, 1'b0};
      ph_out[5] = {2'b01, 3'b100, 3'b001, 1'b0};
      ph_out[6] = {2'b10, 3'b100, 3'b010, 1'b0};
      rst_out = {2'b00, 3'b001, 3'b100, 1'b0};

      vec[0]  = mk(0, 0, -1, ph_out[0], 6);
      vec[1]  = mk(0, 0, -1, ph_out[2], 2);
      vec[2]  = mk(0, 1, -1, ph_out[4], 6);  // walk request during side green
      vec[3]  = mk(0, 0, -1, ph_out[6], 2);
      vec[4]  = mk(1, 0, -1, ph_out[0], 6);  // sensor at expiry -> extension
      vec[5]  = mk(0, 0, -1, ph_out[1], 3);
      vec[6]  = mk(0, 2, -1, ph_out[2], 2);  // pulse on the WALK entry edge
      vec[7]  = mk(0, 0, -1, ph_out[3], 3);
      vec[8]  = mk(0, 0, -1, ph_out[4], 6);
      vec[9]  = mk(0, 0, -1, ph_out[6], 2);
      vec[10] = mk(0, 0, -1, ph_out[0], 6);
      vec[11] = mk(0, 0, -1, ph_out[2], 2);
      vec[12] = mk(0, 0, -1, ph_out[3], 3);  // re-served request
      vec[13] = mk(0, 0, -1, ph_out[4], 6);
      vec[14] = mk(0, 0, 0,  ph_out[6], 2);  // base programmed to 0
      vec[15] = mk(0, 0, 0,  ph_out[0], 1);

      tbl[0] = 4'd6; tbl[1] = 4'd3; tbl[2] = 4'd2;
      tp_val = 4'd6;
      tick_1hz = 0; sensor_sync = 0; walk_req_sync = 0; reset_sync = 1;
      m_ph = 0; m_since = 0; m_left = 0; m_latch = 0;
      @(negedge clk);

      step(0, 0, 1);
      step(0, 0, 1);
      chk("reset_outputs", outs_now(), rst_out);

      for (int i = 0; i < 16; i++) run_phase(i, 1);

      // Reset in the middle of main yellow, with ticks on the reset edge and in the load window
      chk("in_main_yel", outs_now(), ph_out[2]);
      tbl[0] = 4'd6;
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      chk("still_main_yel", outs_now(), ph_out[2]);
      step(1, 0, 1);
      chk("reset_mid_yel", outs_now(), rst_out);
      step(1, 0, 0);
      chk("window_tick1", outs_now(), rst_out);
      step(1, 0, 0);
      chk("window_tick2", outs_now(), rst_out);
      run_phase(0, 3);

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(99) < 3) sensor_sync = ~sensor_sync;
         if ($urandom_range(199) == 0) tbl[$urandom_range(2)] = 4'($urandom_range(15));
         step($urandom_range(3) == 0, $urandom_range(24) == 0, $urandom_range(399) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Sequencing controller for the intersection. It consumes the programmed interval length `tp_val` from the time-parameter store, and drives the `interval` select back to that store. It counts 1 Hz ticks to time each phase and drives the main-road lamps, side-road lamps and pedestrian walk lamp. It sits between the input synchronizers/tick divider and the lamp drivers.

## Interface
Parameters:
- `CNT_W`, default 4: timer width; matches `tp_val` width.

Ports:
- `clk`  in  1: system clock.
- `reset_sync`  in  1: synchronous, active-high reset.
- `tick_1hz`  in  1: one-`clk`-wide enable pulse, once per second.
- `sensor_sync`  in  1: synchronized side-road vehicle sensor, level.
- `walk_req_sync`  in  1: synchronized pedestrian request, single-cycle pulse.
- `tp_val`  in  CNT_W: interval length in seconds. It is valid two `clk` edges after `interval` changes.
- `interval`  out  2: selects the length to use: 00 base, 01 extended, 10 yellow. 11 is never driven.
- `main_lamps`  out  3: {red, yellow, green} for the main road.
- `side_lamps`  out  3: {red, yellow, green} for the side road.
- `walk_lamp`  out  1: pedestrian walk indication.

Reset is synchronous, active-high, and uses a single clock.

## Operation
- States, with the `interval` each one drives:
  - MAIN_GRN_BASE: 00.
  - MAIN_GRN_EXT: 01.
  - MAIN_YEL: 10.
  - WALK: 01.
  - SIDE_GRN_BASE: 00.
  - SIDE_GRN_EXT: 01.
  - SIDE_YEL: 10.
- Transitions happen only on timer expiry:
  - MAIN_GRN_BASE goes to MAIN_GRN_EXT if `sensor_sync`=1 at expiry, otherwise to MAIN_YEL.
  - MAIN_GRN_EXT goes to MAIN_YEL.
  - MAIN_YEL goes to WALK if `walk_latch`=1, otherwise to SIDE_GRN_BASE.
  - WALK goes to SIDE_GRN_BASE.
  - SIDE_GRN_BASE goes to SIDE_GRN_EXT if `sensor_sync`=1 at expiry, otherwise to SIDE_YEL.
  - SIDE_GRN_EXT goes to SIDE_YEL.
  - SIDE_YEL goes to MAIN_GRN_BASE.
- Lamps are a registered function of state:
  - Main green in MAIN_GRN_*, main yellow in MAIN_YEL, main red otherwise. Same pattern for the side road.
  - WALK shows both roads red with `walk_lamp`=1. `walk_lamp`=0 in every other state.
- Walk latch:
  - Set by `walk_req_sync`; cleared on the edge that enters WALK.
  - If a request arrives on that same edge, set wins; the request is served on the next cycle round.
- Timer: CNT_W-bit down-counter.
  - Loaded with `tp_val` at the 2nd `clk` edge after any state change, and at the 2nd edge after reset deassertion.
  - While the load is pending, `tick_1hz` is ignored and expiry cannot occur.
  - Once loaded, each tick decrements the counter. Expiry is a tick arriving while count ≤ 1, so a value of N lasts N ticks.
  - `tp_val`=0 behaves as 1.
- Reprogramming `tp_val` mid-phase does not affect the running count; the new value applies from the next load.

## Timing
- Reset values: state MAIN_GRN_BASE, `interval`=00, `main_lamps`=001, `side_lamps`=100, `walk_lamp`=0, walk latch 0, load pending.
- State, `interval` and lamps all update on the expiry edge, i.e. the edge sampling the final tick. There are no combinational outputs.
- Load pipeline:
  - Edge E: `interval` changes.
  - Edge E+1: the upstream store registers the new `tp_val`.
  - Edge E+2: the counter loads.
- Reset asserted mid-phase: on that edge all outputs take their reset values and the in-flight count is discarded. The load sequence restarts after deassertion.
- A tick coincident with `reset_sync` is ignored.
- `sensor_sync` is sampled only on the expiry edge of a *_GRN_BASE state.

## Structure
- Package `traffic_pkg` holds:
  - The state enum.
  - Interval codes `INT_BASE`=2'b00, `INT_EXT`=2'b01, `INT_YEL`=2'b10.
  - Lamp constants `LAMP_R`=3'b100, `LAMP_Y`=3'b010, `LAMP_G`=3'b001.
- One sub-module, `interval_timer`: takes `load`, `load_val`, `tick`, and outputs `expired`. It contains the down-counter and the zero-as-one rule.
- The FSM, walk latch, load-delay shift register and lamp decode live in the top module.

## Test plan
Defaults after reset are base=6, ext=3, yellow=2.
- No sensor, no walk, after reset: phases last MAIN_GRN_BASE 6, MAIN_YEL 2, SIDE_GRN_BASE 6, SIDE_YEL 2 ticks, then repeat. `interval` follows 00, 10, 00, 10.
- `sensor_sync`=1 at MAIN_GRN_BASE expiry: MAIN_GRN_EXT lasts 3 ticks with `interval`=01, `main_lamps`=001.
- `walk_req_sync` pulse during SIDE_GRN_BASE: no WALK on the current side phase. After the next MAIN_YEL, WALK lasts 3 ticks with both lamps 100 and `walk_lamp`=1.
- Walk pulse coincident with the WALK entry edge: WALK is served, and WALK is entered again on the following round.
- `tp_val` forced to 0: the phase expires on the first tick after the load.
- `reset_sync` mid-MAIN_YEL, plus a tick during the 2-edge load window: outputs return to reset values on the reset edge, the window tick is ignored, and MAIN_GRN_BASE then lasts 6 ticks.
